// File: rtl/mc_cpu_pkg.sv
// Shared encodings, FSM states and ALU operations for the multicycle MIPS core.
// Build with ILLEGAL_TRAP_EN defined to halt on unsupported instructions.
package mc_cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_SLT     = 6'h2A;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLT,
      ALU_OR,
      ALU_LUI
   } alu_op_t;

   function automatic logic [31:0] alu(
      input alu_op_t     op,
      input logic [31:0] x,
      input logic [31:0] y
   );
      logic [31:0] r;
      r = '0;
      case (op)
         ALU_ADD: r = x + y;
         ALU_SUB: r = x - y;
         ALU_SLT: r = {31'b0, $signed(x) < $signed(y)};
         ALU_OR:  r = x | y;
         ALU_LUI: r = {y[15:0], 16'h0000};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mc_cpu_regfile.sv
// GPR file: two async reads, one sync write, sync clear.
// $0 and indices at or above REG_COUNT read as zero and ignore writes.
module mc_cpu_regfile #(
   parameter int REG_COUNT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);

   localparam int AW = $clog2(REG_COUNT);

   logic [31:0] regs [REG_COUNT];

   function automatic logic live(input logic [4:0] a);
      return (a != 5'd0) && (int'(a) < REG_COUNT);
   endfunction

   assign rdata1 = live(raddr1) ? regs[raddr1[AW-1:0]] : '0;
   assign rdata2 = live(raddr2) ? regs[raddr2[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (we && live(waddr)) begin
         regs[waddr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB/HALT over one memory port.
// ILLEGAL_TRAP_EN: unsupported instructions halt instead of acting as NOPs.
module multicycle_cpu
   import mc_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter int          REG_COUNT = 32
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        halted,
   output logic [31:0] pc_dbg
);

`ifdef ILLEGAL_TRAP_EN
   localparam state_t ILL_NX = S_HALT;
`else
   localparam state_t ILL_NX = S_FETCH;
`endif

   state_t      state, state_nx;
   logic [31:0] pc, ir, a, b, imm, res;
   logic [31:0] rd1, rd2, alu_b, alu_y, ea;
   logic [5:0]  opcode, funct;
   logic [4:0]  waddr;
   alu_op_t     alu_op;
   logic        is_sys, is_mem, is_flow, is_wb;

   assign opcode = ir[31:26];
   assign funct  = ir[5:0];
   assign waddr  = (opcode == OP_RTYPE) ? ir[15:11] : ir[20:16];
   assign alu_b  = (opcode == OP_RTYPE) ? b : imm;
   assign alu_y  = alu(alu_op, a, alu_b);
   assign ea     = a + imm;

   mc_cpu_regfile #(.REG_COUNT(REG_COUNT)) u_rf (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (ir[25:21]),
      .raddr2 (ir[20:16]),
      .rdata1 (rd1),
      .rdata2 (rd2),
      .we     (state == S_WB),
      .waddr  (waddr),
      .wdata  (res)
   );

   always_comb begin
      alu_op  = ALU_ADD;
      is_sys  = 1'b0;
      is_mem  = 1'b0;
      is_flow = 1'b0;
      is_wb   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU:    begin alu_op = ALU_ADD; is_wb = 1'b1; end
               FN_SUBU:    begin alu_op = ALU_SUB; is_wb = 1'b1; end
               FN_SLT:     begin alu_op = ALU_SLT; is_wb = 1'b1; end
               FN_SYSCALL: is_sys = 1'b1;
               default:    ;
            endcase
         end
         OP_ORI:       begin alu_op = ALU_OR;  is_wb = 1'b1; end
         OP_LUI:       begin alu_op = ALU_LUI; is_wb = 1'b1; end
         OP_LW, OP_SW: is_mem = 1'b1;
         OP_BEQ, OP_J: is_flow = 1'b1;
         default:      ;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:  if (mem_ready) state_nx = S_DECODE;
         S_DECODE: state_nx = S_EXEC;
         S_EXEC: begin
            unique case (1'b1)
               is_sys:  state_nx = S_HALT;
               is_mem:  state_nx = S_MEM;
               is_flow: state_nx = S_FETCH;
               is_wb:   state_nx = S_WB;
               default: state_nx = ILL_NX;
            endcase
         end
         S_MEM: begin
            if (mem_ready) state_nx = (opcode == OP_LW) ? S_WB : S_FETCH;
         end
         S_WB:    state_nx = S_FETCH;
         default: state_nx = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         ir    <= '0;
         a     <= '0;
         b     <= '0;
         imm   <= '0;
         res   <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  ir <= mem_rdata;
                  pc <= pc + 32'd4;
               end
            end
            S_DECODE: begin
               a   <= rd1;
               b   <= rd2;
               imm <= (opcode == OP_ORI) ? {16'h0000, ir[15:0]}
                                         : {{16{ir[15]}}, ir[15:0]};
            end
            S_EXEC: begin
               res <= alu_y;
               // pc already points past the branch, so the offset adds to it directly
               if (opcode == OP_BEQ && a == b) pc <= pc + {imm[29:0], 2'b00};
               if (opcode == OP_J) pc <= {pc[31:28], ir[25:0], 2'b00};
            end
            S_MEM: if (mem_ready) res <= mem_rdata;
            default: ;
         endcase
      end
   end

   assign mem_req   = !rst && (state == S_FETCH || state == S_MEM);
   assign mem_we    = !rst && (state == S_MEM) && (opcode == OP_SW);
   assign mem_addr  = (state == S_MEM) ? ea : pc;
   assign mem_wdata = b;
   assign halted    = (state == S_HALT);
   assign pc_dbg    = pc;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: program table plus stall/branch/reset sequences.
// Expectations for the illegal-opcode vector follow ILLEGAL_TRAP_EN.
module tb_multicycle_cpu;

   localparam logic [31:0] RPC  = 32'h0000_3000;
   localparam logic [31:0] FILL = 32'hDEAD_BEEF;
   localparam logic [31:0] SYS  = 32'h0000_000C;
   localparam logic [31:0] NOP  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req, mem_we, mem_ready, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

   multicycle_cpu #(.RESET_PC(RPC), .REG_COUNT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .halted    (halted),
      .pc_dbg    (pc_dbg)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [4096];
   logic [31:0] prog [8];
   logic        load = 1'b0;
   int          wait_n = 0;
   int          wcnt = 0;
   int          n_store = 0;

   assign mem_ready = mem_req && (wcnt >= wait_n);
   assign mem_rdata = mem[mem_addr[13:2]];

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 4096; i++) mem[i] <= FILL;
         for (int k = 0; k < 8; k++) mem[3072 + k] <= prog[k];
         n_store <= 0;
      end else if (mem_req && mem_ready && mem_we) begin
         mem[mem_addr[13:2]] <= mem_wdata;
         n_store <= n_store + 1;
      end
      if (mem_req && !mem_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   function automatic logic [31:0] ity(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] im);
      return {op, rs, rt, im};
   endfunction

   function automatic logic [31:0] rty(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   typedef struct {
      logic [31:0]          addr;
      logic [31:0]          exp;
      int                   cyc;
      logic [0:7][31:0]     p;
   } vec_t;

   vec_t vecs[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;

   logic        p_stall = 1'b0;
   logic        p_we;
   logic [31:0] p_addr, p_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: sample at the falling edge and check request stability while stalled.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (p_stall && mem_req)
         chk("req_stable", {mem_we, mem_addr, mem_wdata} == {p_we, p_addr, p_wdata}, 1);
      p_stall = mem_req && !mem_ready;
      p_we    = mem_we;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk("rst_req", {31'b0, mem_req}, 0);
      chk("rst_pc", pc_dbg, RPC);
      chk("rst_halted", {31'b0, halted}, 0);
      rst = 1'b0;
   endtask

   task automatic wait_fetch(input logic [31:0] addr, output int c);
      logic cond, prev;
      prev = mem_req && !mem_we && mem_addr == addr;
      c = -1;
      for (int n = 0; n < 200 && c < 0; n++) begin
         tick();
         cond = mem_req && !mem_we && mem_addr == addr;
         if (cond && !prev) c = cyc;
         prev = cond;
      end
      chk("fetch_seen", {31'b0, c >= 0}, 1);
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] e, input int c,
                       input logic [0:7][31:0] p);
      vec_t v;
      v.addr = a;
      v.exp  = e;
      v.cyc  = c;
      v.p    = p;
      vecs.push_back(v);
   endtask

   initial begin
      int n, c1, c2, c3;
      logic [31:0] ill_exp;
      int ill_cyc;
`ifdef ILLEGAL_TRAP_EN
      ill_exp = FILL;
      ill_cyc = 3;
`else
      ill_exp = 32'h42;
      ill_cyc = 14;
`endif
      push(32'h100, 32'h2468, 15, {ity(6'h0D,0,1,16'h1234), rty(1,1,2,6'h21),
           ity(6'h2B,0,2,16'h0100), SYS, NOP, NOP, NOP, NOP});
      push(32'h104, 32'hFFFF_FFFE, 19, {ity(6'h0D,0,1,16'd5), ity(6'h0D,0,2,16'd7),
           rty(1,2,3,6'h23), ity(6'h2B,0,3,16'h0104), SYS, NOP, NOP, NOP});
      push(32'h108, 32'h1, 19, {ity(6'h0F,0,1,16'h8000), ity(6'h0D,0,2,16'd1),
           rty(1,2,3,6'h2A), ity(6'h2B,0,3,16'h0108), SYS, NOP, NOP, NOP});
      push(32'h10C, 32'h0, 19, {ity(6'h0F,0,1,16'h8000), ity(6'h0D,0,2,16'd1),
           rty(2,1,3,6'h2A), ity(6'h2B,0,3,16'h010C), SYS, NOP, NOP, NOP});
      push(32'h110, 32'hABCD_8001, 15, {ity(6'h0F,0,1,16'hABCD), ity(6'h0D,1,1,16'h8001),
           ity(6'h2B,0,1,16'h0110), SYS, NOP, NOP, NOP, NOP});
      push(32'h114, 32'hFFFF_FFFE, 19, {ity(6'h0F,0,1,16'hFFFF), ity(6'h0D,1,1,16'hFFFF),
           rty(1,1,2,6'h21), ity(6'h2B,0,2,16'h0114), SYS, NOP, NOP, NOP});
      push(32'h118, 32'h0, 11, {ity(6'h0D,0,0,16'h0055), ity(6'h2B,0,0,16'h0118),
           SYS, NOP, NOP, NOP, NOP, NOP});
      push(32'h124, 32'h77, 24, {ity(6'h0D,0,1,16'h0120), ity(6'h0D,0,2,16'h0077),
           ity(6'h2B,1,2,16'hFFFC), ity(6'h23,1,3,16'hFFFC), ity(6'h2B,0,3,16'h0124),
           SYS, NOP, NOP});
      push(32'h128, 32'h0, 10, {{6'h02, 26'h0000C04}, ity(6'h0D,0,1,16'd1),
           ity(6'h0D,0,1,16'd2), ity(6'h0D,0,1,16'd3), ity(6'h2B,0,1,16'h0128),
           SYS, NOP, NOP});
      push(32'h12C, 32'h9, 18, {ity(6'h0D,0,1,16'd1), ity(6'h04,1,0,16'd1),
           ity(6'h0D,0,2,16'd9), ity(6'h2B,0,2,16'h012C), SYS, NOP, NOP, NOP});
      push(32'h130, 32'h0, 14, {ity(6'h0D,0,1,16'd1), ity(6'h04,1,1,16'd1),
           ity(6'h0D,0,2,16'd9), ity(6'h2B,0,2,16'h0130), SYS, NOP, NOP, NOP});
      push(32'h134, ill_exp, ill_cyc, {{6'h3E, 26'h0}, ity(6'h0D,0,1,16'h0042),
           ity(6'h2B,0,1,16'h0134), SYS, NOP, NOP, NOP, NOP});
      push(32'h138, 32'h3, 19, {ity(6'h0D,0,1,16'd3), rty(1,1,9,6'h21),
           rty(9,1,2,6'h21), ity(6'h2B,0,2,16'h0138), SYS, NOP, NOP, NOP});
      push(32'h13C, 32'h22, 15, {ity(6'h0D,0,7,16'h0011), rty(7,7,7,6'h21),
           ity(6'h2B,0,7,16'h013C), SYS, NOP, NOP, NOP, NOP});

      for (int i = 0; i < vecs.size(); i++) begin
         for (int k = 0; k < 8; k++) prog[k] = vecs[i].p[k];
         wait_n = 0;
         do_reset();
         n = 0;
         while (!halted && n < 200) begin
            tick();
            n++;
         end
         chk($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
         chk($sformatf("v%0d_value", i), mem[vecs[i].addr[13:2]], vecs[i].exp);
         for (int k = 0; k < 3; k++) tick();
         chk($sformatf("v%0d_halt_hold", i), {30'b0, mem_req, halted}, 32'h1);
      end

      // ori/addu: two 4-cycle instructions leave PC two words on
      for (int k = 0; k < 8; k++) prog[k] = vecs[0].p[k];
      wait_n = 0;
      do_reset();
      for (int k = 0; k < 8; k++) tick();
      chk("pc_after_8", pc_dbg, RPC + 32'd8);

      // sw then lw with two wait cycles per access
      prog[0] = ity(6'h0D,0,2,16'h2468);
      prog[1] = ity(6'h2B,0,2,16'h0004);
      prog[2] = ity(6'h23,0,3,16'h0004);
      prog[3] = ity(6'h2B,0,3,16'h0008);
      prog[4] = SYS;
      for (int k = 5; k < 8; k++) prog[k] = NOP;
      wait_n = 2;
      do_reset();
      wait_fetch(RPC + 32'd8, c1);
      wait_fetch(RPC + 32'd12, c2);
      chk("lw_cycles", c2 - c1, 9);
      n = 0;
      while (!halted && n < 200) begin
         tick();
         n++;
      end
      chk("sw_data", mem[1], 32'h2468);
      chk("lw_data", mem[2], 32'h2468);
      chk("store_count", n_store, 2);

      // beq back onto itself loops every 3 cycles
      prog[0] = ity(6'h0D,0,1,16'd1);
      prog[1] = ity(6'h04,1,1,16'hFFFF);
      for (int k = 2; k < 8; k++) prog[k] = NOP;
      wait_n = 0;
      do_reset();
      wait_fetch(RPC + 32'd4, c1);
      wait_fetch(RPC + 32'd4, c2);
      wait_fetch(RPC + 32'd4, c3);
      chk("beq_loop1", c2 - c1, 3);
      chk("beq_loop2", c3 - c2, 3);

      // reset lands while a store is stalled
      prog[0] = ity(6'h0D,0,2,16'h0099);
      prog[1] = ity(6'h2B,0,2,16'h0200);
      for (int k = 2; k < 8; k++) prog[k] = NOP;
      wait_n = 6;
      do_reset();
      n = 0;
      while (!(mem_req && mem_we) && n < 50) begin
         tick();
         n++;
      end
      chk("sw_stall_seen", {31'b0, mem_req && mem_we}, 1);
      tick();
      rst = 1'b1;
      #1;
      chk("rst_req_low", {31'b0, mem_req}, 0);
      tick();
      chk("rst_mid_req", {31'b0, mem_req}, 0);
      chk("rst_mid_pc", pc_dbg, RPC);
      rst = 1'b0;
      wait_n = 0;
      #1;
      chk("refetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, RPC});
      tick();
      chk("no_store", n_store, 0);
      chk("no_store_mem", mem[32'h200 >> 2], FILL);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
